// File: rtl/sprite_set_n.sv
// Sprite pixel engine: NUM_SPRITES slots loaded as a shift chain during fetch,
// then X down-count and pattern shift during display, with a registered priority mux.
module sprite_set_n #(
    parameter int NUM_SPRITES = 8,
    parameter int X_BITS      = 8,
    localparam int IDX_W      = $clog2(NUM_SPRITES),
    localparam int OCC_W      = $clog2(NUM_SPRITES + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ce,
    input  logic                 line_start,
    input  logic                 enable,
    input  logic [3:0]           load,
    input  logic [X_BITS+19:0]   load_in,
    output logic [4:0]           pix_bits,
    output logic                 pix_is_sprite0,
    output logic [IDX_W-1:0]     pix_index,
    output logic [OCC_W-1:0]     occupancy,
    output logic                 overflow
);
    localparam int N = NUM_SPRITES;
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(N);

    logic [N-1:0]        valid_q, valid_d;
    logic [N-1:0]        tag_q, tag_d;
    logic [N-1:0]        prio_q, prio_d;
    logic [X_BITS-1:0]   xcnt_q [N];
    logic [X_BITS-1:0]   xcnt_d [N];
    logic [1:0]          pal_q  [N];
    logic [1:0]          pal_d  [N];
    logic [7:0]          hi_q   [N];
    logic [7:0]          hi_d   [N];
    logic [7:0]          lo_q   [N];
    logic [7:0]          lo_d   [N];
    logic [OCC_W-1:0]    occ_q, occ_d;
    logic                ovf_q, ovf_d;
    logic [4:0]          pix_bits_q;
    logic                pix_s0_q;
    logic [IDX_W-1:0]    pix_idx_q;

    logic [4:0]          win_bits;
    logic                win_tag;
    logic [IDX_W-1:0]    win_idx;
    logic [N-1:0]        valid_base;

    logic                ld_tag;
    logic [X_BITS-1:0]   ld_x;
    logic                ld_prio;
    logic [1:0]          ld_pal;
    logic [7:0]          ld_hi;
    logic [7:0]          ld_lo;

    assign ld_tag  = load_in[X_BITS+19];
    assign ld_x    = load_in[X_BITS+18:19];
    assign ld_prio = load_in[18];
    assign ld_pal  = load_in[17:16];
    assign ld_hi   = load_in[15:8];
    assign ld_lo   = load_in[7:0];

    // line_start clears valid before any push in the same cycle
    assign valid_base = line_start ? {N{1'b0}} : valid_q;

    // Slot next-state: load shifts fields down the chain, otherwise run counts/shifts
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        prio_d  = prio_q;
        xcnt_d  = xcnt_q;
        pal_d   = pal_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        occ_d   = occ_q;
        ovf_d   = ovf_q;
        if (ce) begin
            if (line_start) begin
                valid_d = {N{1'b0}};
                occ_d   = {OCC_W{1'b0}};
                ovf_d   = 1'b0;
            end else begin
                valid_d = valid_q;
            end
            if (load != 4'd0) begin
                for (int i = 0; i < N - 1; i++) begin
                    if (load[3]) xcnt_d[i] = xcnt_q[i+1]; else xcnt_d[i] = xcnt_q[i];
                    if (load[2]) pal_d[i]  = pal_q[i+1];  else pal_d[i]  = pal_q[i];
                    if (load[1]) lo_d[i]   = lo_q[i+1];   else lo_d[i]   = lo_q[i];
                    if (load[0]) hi_d[i]   = hi_q[i+1];   else hi_d[i]   = hi_q[i];
                end
                if (load[3]) begin
                    xcnt_d[N-1] = ld_x;
                    tag_d       = {ld_tag, tag_q[N-1:1]};
                    valid_d     = {1'b1, valid_base[N-1:1]};
                    if (occ_d == OCC_FULL) begin
                        ovf_d = 1'b1;
                    end else begin
                        occ_d = occ_d + OCC_W'(1);
                    end
                end else begin
                    tag_d = tag_q;
                end
                if (load[2]) begin
                    pal_d[N-1] = ld_pal;
                    prio_d     = {ld_prio, prio_q[N-1:1]};
                end else begin
                    prio_d = prio_q;
                end
                if (load[1]) lo_d[N-1] = ld_lo; else lo_d[N-1] = lo_q[N-1];
                if (load[0]) hi_d[N-1] = ld_hi; else hi_d[N-1] = hi_q[N-1];
            end else if (enable) begin
                for (int i = 0; i < N; i++) begin
                    if (xcnt_q[i] != {X_BITS{1'b0}}) begin
                        xcnt_d[i] = xcnt_q[i] - X_BITS'(1);
                    end else begin
                        hi_d[i] = {hi_q[i][6:0], 1'b0};
                        lo_d[i] = {lo_q[i][6:0], 1'b0};
                    end
                end
            end else begin
                occ_d = occ_d;
            end
        end else begin
            occ_d = occ_q;
        end
    end

    // Priority mux: scan high to low so the lowest opaque index is left standing
    always_comb begin
        win_bits = 5'd0;
        win_tag  = 1'b0;
        win_idx  = {IDX_W{1'b0}};
        for (int i = N - 1; i >= 0; i--) begin
            if (valid_q[i] && (xcnt_q[i] == {X_BITS{1'b0}}) && (hi_q[i][7] || lo_q[i][7])) begin
                win_bits = {prio_q[i], pal_q[i], hi_q[i][7], lo_q[i][7]};
                win_tag  = tag_q[i];
                win_idx  = IDX_W'(i);
            end else begin
                win_bits = win_bits;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= {N{1'b0}};
            tag_q      <= {N{1'b0}};
            prio_q     <= {N{1'b0}};
            for (int i = 0; i < N; i++) begin
                xcnt_q[i] <= {X_BITS{1'b0}};
                pal_q[i]  <= 2'd0;
                hi_q[i]   <= 8'd0;
                lo_q[i]   <= 8'd0;
            end
            occ_q      <= {OCC_W{1'b0}};
            ovf_q      <= 1'b0;
            pix_bits_q <= 5'd0;
            pix_s0_q   <= 1'b0;
            pix_idx_q  <= {IDX_W{1'b0}};
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            prio_q  <= prio_d;
            xcnt_q  <= xcnt_d;
            pal_q   <= pal_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            occ_q   <= occ_d;
            ovf_q   <= ovf_d;
            if (ce) begin
                pix_bits_q <= enable ? win_bits : 5'd0;
                pix_s0_q   <= enable ? win_tag : 1'b0;
                pix_idx_q  <= enable ? win_idx : {IDX_W{1'b0}};
            end
        end
    end

    assign pix_bits       = pix_bits_q;
    assign pix_is_sprite0 = pix_s0_q;
    assign pix_index      = pix_idx_q;
    assign occupancy      = occ_q;
    assign overflow       = ovf_q;
endmodule

// File: tb/tb_sprite_set_n.sv
// Self-checking bench for sprite_set_n: directed scenarios plus randomized
// traffic against a queue-of-sprites reference model.
module tb_sprite_set_n;
    localparam int N  = 8;
    localparam int XB = 8;
    localparam int IW = 3;
    localparam int OW = 4;

    logic            clk = 1'b0;
    logic            rst_n, ce, line_start, enable;
    logic [3:0]      load;
    logic [XB+19:0]  load_in;
    logic [4:0]      pix_bits;
    logic            pix_is_sprite0;
    logic [IW-1:0]   pix_index;
    logic [OW-1:0]   occupancy;
    logic            overflow;

    int tests_run = 0;
    int tests_failed = 0;

    sprite_set_n #(.NUM_SPRITES(N), .X_BITS(XB)) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .line_start(line_start), .enable(enable),
        .load(load), .load_in(load_in), .pix_bits(pix_bits),
        .pix_is_sprite0(pix_is_sprite0), .pix_index(pix_index),
        .occupancy(occupancy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Reference model: list of loaded sprites, oldest first; each tracks the
    // remaining X delay and how many pattern columns have been emitted.
    int       qlen;
    bit       m_ovf;
    int       m_x [N];
    int       m_s [N];
    bit [7:0] m_hi [N];
    bit [7:0] m_lo [N];
    bit [1:0] m_pal [N];
    bit       m_prio [N];
    bit       m_tag [N];
    bit [4:0] e_bits;
    bit       e_s0;
    int       e_idx;

    function automatic logic [XB+19:0] spr(bit tag, int x, bit prio, bit [1:0] pal,
                                           bit [7:0] hi, bit [7:0] lo);
        return {tag, XB'(x), prio, pal, hi, lo};
    endfunction

    task automatic model_reset();
        qlen = 0; m_ovf = 0; e_bits = 5'd0; e_s0 = 1'b0; e_idx = 0;
    endtask

    task automatic model_clock();
        bit h, l;
        if (!ce) return;
        e_bits = 5'd0; e_s0 = 1'b0; e_idx = 0;
        if (enable) begin
            for (int k = qlen - 1; k >= 0; k--) begin
                h = (m_s[k] < 8) ? m_hi[k][7 - m_s[k]] : 1'b0;
                l = (m_s[k] < 8) ? m_lo[k][7 - m_s[k]] : 1'b0;
                if (m_x[k] == 0 && (h || l)) begin
                    e_bits = {m_prio[k], m_pal[k], h, l};
                    e_s0   = m_tag[k];
                    e_idx  = N - qlen + k;
                end
            end
        end
        if (line_start) begin qlen = 0; m_ovf = 0; end
        if (load[3]) begin
            if (qlen == N) begin
                for (int k = 0; k < N - 1; k++) begin
                    m_x[k] = m_x[k+1]; m_s[k] = m_s[k+1]; m_hi[k] = m_hi[k+1];
                    m_lo[k] = m_lo[k+1]; m_pal[k] = m_pal[k+1];
                    m_prio[k] = m_prio[k+1]; m_tag[k] = m_tag[k+1];
                end
                qlen = N - 1;
                m_ovf = 1;
            end
            m_tag[qlen]  = load_in[XB+19];
            m_x[qlen]    = int'(load_in[XB+18:19]);
            m_prio[qlen] = load_in[18];
            m_pal[qlen]  = load_in[17:16];
            m_hi[qlen]   = load_in[15:8];
            m_lo[qlen]   = load_in[7:0];
            m_s[qlen]    = 0;
            qlen++;
        end else if (load == 4'd0 && enable) begin
            for (int k = 0; k < qlen; k++) begin
                if (m_x[k] != 0) m_x[k]--;
                else if (m_s[k] < 8) m_s[k]++;
            end
        end
    endtask

    task automatic cyc(input bit c, input bit ls, input bit en, input bit [3:0] ld,
                       input logic [XB+19:0] din);
        ce = c; line_start = ls; enable = en; load = ld; load_in = din;
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ce = 1'b0; line_start = 1'b0; enable = 1'b0; load = 4'd0; load_in = '0;
        model_reset();
        #13;
        tests_run++;
        if (pix_bits !== 5'd0 || pix_is_sprite0 !== 1'b0 || pix_index !== 3'd0 ||
            occupancy !== 4'd0 || overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: bits=%b s0=%b idx=%0d occ=%0d ovf=%b, expected all 0",
                     pix_bits, pix_is_sprite0, pix_index, occupancy, overflow);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 10; k++) begin
            cyc(1, 0, 1, 4'd0, '0);
            tests_run++;
            if (pix_bits !== 5'd0 || occupancy !== 4'd0 || overflow !== 1'b0) begin
                tests_failed++;
                $display("FAIL empty_line[%0d]: bits=%b occ=%0d ovf=%b, expected 0/0/0",
                         k, pix_bits, occupancy, overflow);
            end
        end
    endtask

    task automatic test_single_sprite();
        bit [4:0] exp;
        cyc(1, 1, 0, 4'hF, spr(1, 3, 0, 2'd2, 8'h80, 8'h80));
        for (int k = 0; k < 10; k++) begin
            cyc(1, 0, 1, 4'd0, '0);
            exp = (k == 3) ? 5'b01011 : 5'd0;
            tests_run++;
            if (pix_bits !== exp || pix_is_sprite0 !== (k == 3) ||
                pix_index !== ((k == 3) ? 3'(N - 1) : 3'd0)) begin
                tests_failed++;
                $display("FAIL single_sprite[%0d]: bits=%b s0=%b idx=%0d, expected %b s0=%0d idx=%0d",
                         k, pix_bits, pix_is_sprite0, pix_index, exp, (k == 3),
                         (k == 3) ? N - 1 : 0);
            end
        end
    endtask

    task automatic test_priority();
        bit [4:0] exp;
        bit [2:0] exp_idx;
        cyc(1, 1, 0, 4'hF, spr(0, 0, 0, 2'd1, 8'h00, 8'hFF));
        cyc(1, 0, 0, 4'hF, spr(0, 0, 0, 2'd3, 8'h00, 8'hFF));
        for (int k = 0; k < 8; k++) begin
            cyc(1, 0, 1, 4'd0, '0);
            tests_run++;
            if (pix_bits !== 5'b00101 || pix_index !== 3'(N - 2)) begin
                tests_failed++;
                $display("FAIL priority_full[%0d]: bits=%b idx=%0d, expected 00101 idx=%0d",
                         k, pix_bits, pix_index, N - 2);
            end
        end
        cyc(1, 1, 0, 4'hF, spr(0, 0, 0, 2'd1, 8'h00, 8'h0F));
        cyc(1, 0, 0, 4'hF, spr(0, 0, 0, 2'd3, 8'h00, 8'hFF));
        for (int k = 0; k < 8; k++) begin
            cyc(1, 0, 1, 4'd0, '0);
            exp     = (k < 4) ? 5'b01101 : 5'b00101;
            exp_idx = (k < 4) ? 3'(N - 1) : 3'(N - 2);
            tests_run++;
            if (pix_bits !== exp || pix_index !== exp_idx || pix_is_sprite0 !== 1'b0) begin
                tests_failed++;
                $display("FAIL priority_partial[%0d]: bits=%b idx=%0d, expected %b idx=%0d",
                         k, pix_bits, pix_index, exp, exp_idx);
            end
        end
    endtask

    task automatic test_overflow();
        cyc(1, 1, 0, 4'hF, spr(0, 0, 0, 2'd1, 8'h00, 8'hFF));
        for (int k = 1; k <= N; k++) begin
            cyc(1, 0, 0, 4'hF, spr(0, 0, 0, 2'd2, 8'h00, 8'hFF));
            tests_run++;
            if (occupancy !== 4'((k < N) ? k + 1 : N) || overflow !== (k == N)) begin
                tests_failed++;
                $display("FAIL overflow_push[%0d]: occ=%0d ovf=%b, expected occ=%0d ovf=%0d",
                         k, occupancy, overflow, (k < N) ? k + 1 : N, (k == N));
            end
        end
        cyc(1, 1, 1, 4'd0, '0);
        cyc(1, 0, 1, 4'd0, '0);
        tests_run++;
        if (occupancy !== 4'd0 || overflow !== 1'b0 || pix_bits !== 5'd0) begin
            tests_failed++;
            $display("FAIL overflow_clear: occ=%0d ovf=%b bits=%b, expected 0/0/0",
                     occupancy, overflow, pix_bits);
        end
    endtask

    task automatic test_line_start_push();
        cyc(1, 1, 0, 4'hF, spr(0, 0, 0, 2'd1, 8'h00, 8'hFF));
        cyc(1, 0, 0, 4'hF, spr(0, 0, 0, 2'd1, 8'h00, 8'hFF));
        cyc(1, 0, 0, 4'hF, spr(0, 0, 0, 2'd1, 8'h00, 8'hFF));
        cyc(1, 1, 0, 4'hF, spr(1, 0, 0, 2'd3, 8'h00, 8'hFF));
        tests_run++;
        if (occupancy !== 4'd1 || overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL ls_push_occ: occ=%0d ovf=%b, expected 1/0", occupancy, overflow);
        end
        cyc(1, 0, 1, 4'd0, '0);
        tests_run++;
        if (pix_bits !== 5'b01101 || pix_index !== 3'(N - 1) || pix_is_sprite0 !== 1'b1) begin
            tests_failed++;
            $display("FAIL ls_push_pix: bits=%b idx=%0d s0=%b, expected 01101 idx=%0d s0=1",
                     pix_bits, pix_index, pix_is_sprite0, N - 1);
        end
    endtask

    task automatic test_ce_hold_and_reset();
        bit [4:0] seq [2];
        cyc(1, 1, 0, 4'hF, spr(0, 2, 1, 2'd1, 8'b1011_0000, 8'h00));
        for (int k = 0; k < 3; k++) cyc(1, 0, 1, 4'd0, '0);
        tests_run++;
        if (pix_bits !== 5'b10110) begin
            tests_failed++;
            $display("FAIL ce_first_bit: bits=%b, expected 10110", pix_bits);
        end
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 1, 4'd0, '0);
            tests_run++;
            if (pix_bits !== 5'b10110 || occupancy !== 4'd1) begin
                tests_failed++;
                $display("FAIL ce_hold[%0d]: bits=%b occ=%0d, expected 10110 occ=1",
                         k, pix_bits, occupancy);
            end
        end
        seq[0] = 5'b00000; seq[1] = 5'b10110;
        for (int k = 0; k < 2; k++) begin
            cyc(1, 0, 1, 4'd0, '0);
            tests_run++;
            if (pix_bits !== seq[k]) begin
                tests_failed++;
                $display("FAIL ce_resume[%0d]: bits=%b, expected %b", k, pix_bits, seq[k]);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        tests_run++;
        if (pix_bits !== 5'd0 || pix_is_sprite0 !== 1'b0 || pix_index !== 3'd0 ||
            occupancy !== 4'd0 || overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: bits=%b s0=%b idx=%0d occ=%0d ovf=%b, expected all 0",
                     pix_bits, pix_is_sprite0, pix_index, occupancy, overflow);
        end
        @(negedge clk); rst_n = 1'b1;
        cyc(1, 0, 1, 4'd0, '0);
        tests_run++;
        if (pix_bits !== 5'd0 || occupancy !== 4'd0) begin
            tests_failed++;
            $display("FAIL post_reset_empty: bits=%b occ=%0d, expected 0/0", pix_bits, occupancy);
        end
    endtask

    task automatic test_random();
        bit c, ls, en, push;
        for (int k = 0; k < 800; k++) begin
            c    = ($urandom_range(0, 99) < 90);
            ls   = ($urandom_range(0, 99) < 4);
            push = ($urandom_range(0, 99) < 20);
            en   = ($urandom_range(0, 99) < 85);
            cyc(c, ls, en, push ? 4'hF : 4'd0,
                spr(1'($urandom), $urandom_range(0, 10), 1'($urandom), 2'($urandom),
                    8'($urandom), 8'($urandom)));
            tests_run++;
            if (pix_bits !== e_bits || pix_is_sprite0 !== e_s0 || pix_index !== 3'(e_idx) ||
                occupancy !== 4'(qlen) || overflow !== m_ovf) begin
                tests_failed++;
                $display("FAIL random[%0d]: bits=%b s0=%b idx=%0d occ=%0d ovf=%b, expected %b s0=%b idx=%0d occ=%0d ovf=%b",
                         k, pix_bits, pix_is_sprite0, pix_index, occupancy, overflow,
                         e_bits, e_s0, e_idx, qlen, m_ovf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_sprite();
        test_priority();
        test_overflow();
        test_line_start_push();
        test_ce_hold_and_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
